// File: rtl/eight_bit_operand_loader_module_pkg.sv
// Shared state encodings and defaults for the two-byte operand loader.
package eight_bit_operand_loader_module_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    PRESENT = 2'b10
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/eight_bit_operand_loader_module_if.sv
// Byte-in / operand-pair-out bus between a producer, the loader and the downstream mux.
interface eight_bit_operand_loader_module_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sel;
  logic       in_ready;
  logic       flush;
  logic [7:0] a;
  logic [7:0] b;
  logic       s;
  logic       out_valid;
  logic       out_ack;
  logic       timeout_err;

  modport slave (
    input  in_data, in_valid, in_sel, flush, out_ack,
    output in_ready, a, b, s, out_valid, timeout_err
  );

  modport master (
    output in_data, in_valid, in_sel, flush, out_ack,
    input  in_ready, a, b, s, out_valid, timeout_err
  );
endinterface

// File: rtl/eight_bit_operand_loader_module_reg.sv
// 8-bit register with load enable and asynchronous active-low clear.
module eight_bit_enable_register_module (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] q_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= 8'h00;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/eight_bit_operand_loader_module.sv
// Collects two bytes from a shared bus into operands a/b plus select s and
// presents them until acknowledged or until the wait counter times out.
module eight_bit_operand_loader_module
  import eight_bit_operand_loader_module_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                              clk,
  input logic                              reset_n,
  eight_bit_operand_loader_module_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  logic       s_reg;
  logic       terr_reg;

  logic       ld_en [2];
  logic [7:0] ld_q  [2];

  // Flush suppresses both operand loads so no byte slips in on an abort cycle.
  assign ld_en[0] = !bus.flush && (state_reg == LOAD_A) && bus.in_valid;
  assign ld_en[1] = !bus.flush && (state_reg == LOAD_B) && bus.in_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      eight_bit_enable_register_module u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ld_en[gi]),
        .d       (bus.in_data),
        .q       (ld_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= LOAD_A;
      cnt_reg   <= 8'h00;
      s_reg     <= 1'b0;
      terr_reg  <= 1'b0;
    end else if (bus.flush) begin
      state_reg <= LOAD_A;
      cnt_reg   <= 8'h00;
    end else begin
      case (state_reg)
        LOAD_A: begin
          if (bus.in_valid) begin
            state_reg <= LOAD_B;
            terr_reg  <= 1'b0;
          end
        end
        LOAD_B: begin
          if (bus.in_valid) begin
            state_reg <= PRESENT;
            s_reg     <= bus.in_sel;
            cnt_reg   <= 8'h00;
          end
        end
        PRESENT: begin
          // An ack arriving on the timeout cycle wins: the pair was consumed.
          if (bus.out_ack) begin
            state_reg <= LOAD_A;
            cnt_reg   <= 8'h00;
          end else if (cnt_reg == TO_LAST) begin
            state_reg <= LOAD_A;
            cnt_reg   <= 8'h00;
            terr_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= LOAD_A;
          cnt_reg   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign bus.out_valid   = (state_reg == PRESENT);
  assign bus.a           = ld_q[0];
  assign bus.b           = ld_q[1];
  assign bus.s           = s_reg;
  assign bus.timeout_err = terr_reg;

endmodule

// File: tb/tb_eight_bit_operand_loader_module.sv
// Scoreboard bench: stimulus feeds a pair-level reference model; monitors compare DUT outputs.
module tb_eight_bit_operand_loader_module;

  localparam int TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  eight_bit_operand_loader_module_if bus ();

  eight_bit_operand_loader_module #(.TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } pair_t;

  typedef struct packed {
    logic       ready;
    logic       valid;
    logic       terr;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
  } status_t;

  pair_t   pair_q[$];
  status_t status_q[$];

  int checks = 0;
  int failures = 0;
  bit scb_on = 1'b0;

  // Reference model: a pair being assembled, or a pair on show with a wait age.
  bit         m_have_a;
  bit         m_showing;
  int         m_age;
  bit         m_terr;
  logic [7:0] m_a, m_b;
  logic       m_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_have_a = 0; m_showing = 0; m_age = 0; m_terr = 0;
    m_a = 8'h00; m_b = 8'h00; m_s = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit sel, input bit ack, input bit fl);
    @(negedge clk);
    bus.in_valid = v; bus.in_data = d; bus.in_sel = sel;
    bus.out_ack = ack; bus.flush = fl;
    if (fl) begin
      m_have_a = 0; m_showing = 0; m_age = 0;
    end else if (!m_showing) begin
      if (v && !m_have_a) begin
        m_a = d; m_terr = 0; m_have_a = 1;
      end else if (v) begin
        m_b = d; m_s = sel; m_have_a = 0; m_showing = 1; m_age = 0;
        if (scb_on) pair_q.push_back('{a: m_a, b: m_b, s: m_s});
      end
    end else begin
      m_age++;
      if (ack) m_showing = 0;
      else if (m_age >= TB_TIMEOUT) begin
        m_showing = 0; m_terr = 1;
      end
    end
    if (scb_on)
      status_q.push_back('{ready: !m_showing, valid: m_showing, terr: m_terr,
                           a: m_a, b: m_b, s: m_s});
  endtask

  // Monitor: every scoreboarded cycle, plus a pair check whenever out_valid rises.
  initial begin
    status_t st;
    pair_t   pr;
    logic    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (status_q.size() > 0) begin
        st = status_q.pop_front();
        chk("in_ready", 32'(bus.in_ready), 32'(st.ready));
        chk("out_valid", 32'(bus.out_valid), 32'(st.valid));
        chk("timeout_err", 32'(bus.timeout_err), 32'(st.terr));
        chk("a_hold", 32'(bus.a), 32'(st.a));
        chk("b_hold", 32'(bus.b), 32'(st.b));
        chk("s_hold", 32'(bus.s), 32'(st.s));
        if (bus.out_valid && !prev_valid) begin
          if (pair_q.size() == 0) begin
            chk("pair_unexpected", 32'(bus.out_valid), 32'd0);
          end else begin
            pr = pair_q.pop_front();
            chk("pair", 32'({bus.a, bus.b, bus.s}), 32'(pr));
            $display("pair a=%02h b=%02h s=%0d", bus.a, bus.b, bus.s);
          end
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    bus.in_valid = 0; bus.in_data = 8'h00; bus.in_sel = 0;
    bus.out_ack = 0; bus.flush = 0;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_a", 32'(bus.a), 32'd0);
    chk("rst_b", 32'(bus.b), 32'd0);
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scb_on = 1'b1;

    // Basic load, ack, next byte into a only.
    cycle(1, 8'h3C, 0, 0, 0);
    cycle(1, 8'hA5, 1, 0, 0);
    cycle(0, 8'hFF, 0, 1, 0);
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h77, 0, 0, 0);
    // Timeout after TB_TIMEOUT unacked cycles, then cleared by the next A byte.
    repeat (TB_TIMEOUT) cycle(0, 8'h00, 0, 0, 0);
    cycle(1, 8'h42, 1, 0, 0);
    cycle(1, 8'h99, 0, 0, 0);
    // Ack arriving exactly in the timeout cycle.
    repeat (TB_TIMEOUT - 1) cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 0, 1, 0);
    // Flush in LOAD_B with a valid byte present.
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 1, 0, 1);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h44, 1, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3, 0) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(2, 0) == 0, $urandom_range(15, 0) == 0);

    cycle(0, 8'h00, 0, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);
    scb_on = 1'b0;
    @(posedge clk);
    #2;
    chk("pairs_drained", 32'(pair_q.size()), 32'd0);
    chk("status_drained", 32'(status_q.size()), 32'd0);

    // Asynchronous reset in the middle of a PRESENT cycle.
    cycle(1, 8'hC3, 0, 0, 0);
    cycle(1, 8'h3C, 1, 0, 0);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ack = 0; bus.flush = 0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_a", 32'(bus.a), 32'd0);
    chk("arst_b", 32'(bus.b), 32'd0);
    chk("arst_s", 32'(bus.s), 32'd0);
    chk("arst_terr", 32'(bus.timeout_err), 32'd0);
    #1 reset_n = 1'b1;
    model_reset();
    cycle(1, 8'h5A, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("post_rst_a", 32'(bus.a), 32'h5A);
    chk("post_rst_b", 32'(bus.b), 32'h00);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
